// File: rtl/regfile_pkg.sv
// Shared constants and types for the lane-configurable register file.
// Optional feature macro used across this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned DEF_LANES  = 2;
    localparam int unsigned DEF_LANE_W = 32;
    localparam int unsigned DEF_NREG   = 32;

    localparam logic MODE_SPLIT   = 1'b0;
    localparam logic MODE_UNIFIED = 1'b1;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StSwitch
    } state_t;

endpackage

// File: rtl/regfile_lanes_sb_if.sv
// Issue / writeback / read bundle between the datapath (master) and the register file (slave).
interface regfile_lanes_sb_if import regfile_pkg::*; #(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned LANE_W = DEF_LANE_W,
    parameter int unsigned NREG   = DEF_NREG
);
    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned W  = LANES * LANE_W;

    logic                  mode_req;
    logic                  mode;
    logic                  mode_busy;
    logic [LANES-1:0]      iss_valid;
    logic [LANES*AW-1:0]   iss_rd;
    logic [LANES-1:0]      iss_ready;
    logic [LANES-1:0]      we;
    logic [LANES*AW-1:0]   wr_addr;
    logic [W-1:0]          wr_data;
    logic [LANES*AW-1:0]   rs1;
    logic [LANES*AW-1:0]   rs2;
    logic [LANES*W-1:0]    rd1;
    logic [LANES*W-1:0]    rd2;
    logic [LANES-1:0]      rs1_busy;
    logic [LANES-1:0]      rs2_busy;

    modport master (
        output mode_req, iss_valid, iss_rd, we, wr_addr, wr_data, rs1, rs2,
        input  mode, mode_busy, iss_ready, rd1, rd2, rs1_busy, rs2_busy
    );

    modport slave (
        input  mode_req, iss_valid, iss_rd, we, wr_addr, wr_data, rs1, rs2,
        output mode, mode_busy, iss_ready, rd1, rd2, rs1_busy, rs2_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-lane busy scoreboard: issue sets, writeback clears, mode switch wipes.
// With REGFILE_BYPASS_EN the visible busy vector hides same-cycle clearing writebacks.
module regfile_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            active,
    input  logic            run,
    input  logic            clear,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    output logic [NREG-1:0] busy,
    output logic            busy_any
);

    logic [NREG-1:0] busy_q, busy_d, set_vec, clr_vec;

    always_comb begin
        iss_ready = run && active && !busy_q[iss_rd];
        set_vec   = '0;
        clr_vec   = '0;
        if (iss_valid && iss_ready && (iss_rd != '0)) set_vec[iss_rd] = 1'b1;
        if (we && active) clr_vec[wr_addr] = 1'b1;
        // Set wins over a same-cycle clear of the same register.
        busy_d   = clear ? '0 : ((busy_q & ~clr_vec) | set_vec);
        busy_any = |busy_q;
`ifdef REGFILE_BYPASS_EN
        busy     = busy_q & ~(clr_vec & ~set_vec);
`else
        busy     = busy_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/regfile_lanes_sb.sv
// Lane-split/unified register file with per-lane busy scoreboards and a draining mode switch.
// REGFILE_BYPASS_EN enables write-through forwarding of same-cycle writes to reads.
module regfile_lanes_sb import regfile_pkg::*; #(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned LANE_W = DEF_LANE_W,
    parameter int unsigned NREG   = DEF_NREG
) (
    input logic               clk,
    input logic               rst,
    regfile_lanes_sb_if.slave bus
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned W  = LANES * LANE_W;

    state_t          state_q;
    logic            mode_q, mode_busy_q;
    logic [W-1:0]    regs_q [NREG];
    logic [AW-1:0]   iss_rd_a [LANES];
    logic [AW-1:0]   wr_addr_a [LANES];
    logic [AW-1:0]   rs1_a [LANES];
    logic [AW-1:0]   rs2_a [LANES];
    logic [NREG-1:0] busy_lane [LANES];
    logic [LANES-1:0] active, busy_any, iss_ready;
    logic            run, sw;

    assign run = (state_q == StRun);
    assign sw  = (state_q == StSwitch);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign iss_rd_a[l]  = bus.iss_rd[l*AW +: AW];
        assign wr_addr_a[l] = bus.wr_addr[l*AW +: AW];
        assign rs1_a[l]     = bus.rs1[l*AW +: AW];
        assign rs2_a[l]     = bus.rs2[l*AW +: AW];
        assign active[l]    = (l == 0) ? 1'b1 : (mode_q == MODE_SPLIT);

        regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
            .clk       (clk),
            .rst       (rst),
            .active    (active[l]),
            .run       (run),
            .clear     (sw),
            .iss_valid (bus.iss_valid[l]),
            .iss_rd    (iss_rd_a[l]),
            .iss_ready (iss_ready[l]),
            .we        (bus.we[l]),
            .wr_addr   (wr_addr_a[l]),
            .busy      (busy_lane[l]),
            .busy_any  (busy_any[l])
        );
    end

    // Mode FSM: drain all pending writes, then flip mode in a single SWITCH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            mode_q      <= MODE_SPLIT;
            mode_busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.mode_req != mode_q) begin
                        state_q     <= StDrain;
                        mode_busy_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (busy_any == '0) state_q <= StSwitch;
                end
                StSwitch: begin
                    mode_q      <= bus.mode_req;
                    state_q     <= StRun;
                    mode_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= StRun;
                    mode_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (mode_q == MODE_UNIFIED) begin
            if (bus.we[0] && (wr_addr_a[0] != '0)) regs_q[wr_addr_a[0]] <= bus.wr_data;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.we[l] && (wr_addr_a[l] != '0)) begin
                    regs_q[wr_addr_a[l]][l*LANE_W +: LANE_W] <= bus.wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    function automatic logic [W-1:0] read_word(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = (a == '0) ? '0 : regs_q[a];
`ifdef REGFILE_BYPASS_EN
        if (a != '0) begin
            if (mode_q == MODE_UNIFIED) begin
                if (bus.we[0] && (wr_addr_a[0] == a)) v = bus.wr_data;
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    if (bus.we[l] && (wr_addr_a[l] == a)) begin
                        v[l*LANE_W +: LANE_W] = bus.wr_data[l*LANE_W +: LANE_W];
                    end
                end
            end
        end
`endif
        return v;
    endfunction

    always_comb begin
        bus.rd1      = '0;
        bus.rd2      = '0;
        bus.rs1_busy = '0;
        bus.rs2_busy = '0;
        for (int p = 0; p < LANES; p++) begin
            bus.rd1[p*W +: W] = read_word(rs1_a[p]);
            bus.rd2[p*W +: W] = read_word(rs2_a[p]);
            // Unified mode consults lane 0's scoreboard for every port.
            if (mode_q == MODE_UNIFIED) begin
                bus.rs1_busy[p] = busy_lane[0][rs1_a[p]];
                bus.rs2_busy[p] = busy_lane[0][rs2_a[p]];
            end else begin
                bus.rs1_busy[p] = busy_lane[p][rs1_a[p]];
                bus.rs2_busy[p] = busy_lane[p][rs2_a[p]];
            end
        end
    end

    assign bus.mode      = mode_q;
    assign bus.mode_busy = mode_busy_q;
    assign bus.iss_ready = iss_ready;

endmodule

// File: tb/tb_regfile_lanes_sb.sv
// Directed and randomized bench for regfile_lanes_sb against a behavioural model.
module tb_regfile_lanes_sb;
    import regfile_pkg::*;

    localparam int unsigned LANES  = 2;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned W      = LANES * LANE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_lanes_sb_if #(.LANES(LANES), .LANE_W(LANE_W), .NREG(NREG)) bus ();

    regfile_lanes_sb #(.LANES(LANES), .LANE_W(LANE_W), .NREG(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: register array, busy sets per lane, mode and switch phase.
    logic [W-1:0] regs_m [NREG];
    bit           busy_m [LANES][NREG];
    bit           mode_m;
    int           phase_m; // 0 running, 1 draining, 2 switching

    function automatic int unsigned fld(input logic [LANES*AW-1:0] v, input int l);
        return int'(v[l*AW +: AW]);
    endfunction

    function automatic bit lane_on(input int l);
        return (mode_m == 1'b0) || (l == 0);
    endfunction

    function automatic bit can_issue(input int l);
        return phase_m == 0 && lane_on(l) && !busy_m[l][fld(bus.iss_rd, l)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            regs_m[i] = '0;
            for (int l = 0; l < LANES; l++) busy_m[l][i] = 1'b0;
        end
        mode_m  = 1'b0;
        phase_m = 0;
    endtask

    function automatic logic [W-1:0] exp_read(input int unsigned a);
        logic [W-1:0] v;
        v = (a == 0) ? '0 : regs_m[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0) begin
            if (mode_m) begin
                if (bus.we[0] && fld(bus.wr_addr, 0) == a) v = bus.wr_data;
            end else begin
                for (int l = 0; l < LANES; l++)
                    if (bus.we[l] && fld(bus.wr_addr, l) == a)
                        v[l*LANE_W +: LANE_W] = bus.wr_data[l*LANE_W +: LANE_W];
            end
        end
`endif
        return v;
    endfunction

    function automatic bit exp_busy(input int p, input int unsigned a);
        int src;
        bit b;
        src = mode_m ? 0 : p;
        b = busy_m[src][a];
`ifdef REGFILE_BYPASS_EN
        if (bus.we[src] && fld(bus.wr_addr, src) == a &&
            !(bus.iss_valid[src] && can_issue(src) && fld(bus.iss_rd, src) == a))
            b = 1'b0;
`endif
        return b;
    endfunction

    task automatic check_outputs();
        logic [LANES-1:0]   rdy, b1, b2;
        logic [LANES*W-1:0] e1, e2;
        for (int l = 0; l < LANES; l++) begin
            rdy[l]          = can_issue(l);
            e1[l*W +: W]    = exp_read(fld(bus.rs1, l));
            e2[l*W +: W]    = exp_read(fld(bus.rs2, l));
            b1[l]           = exp_busy(l, fld(bus.rs1, l));
            b2[l]           = exp_busy(l, fld(bus.rs2, l));
        end
        check_eq("mode", bus.mode, mode_m);
        check_eq("mode_busy", bus.mode_busy, phase_m != 0);
        check_eq("iss_ready", bus.iss_ready, rdy);
        check_eq("rd1", bus.rd1, e1);
        check_eq("rd2", bus.rd2, e2);
        check_eq("rs1_busy", bus.rs1_busy, b1);
        check_eq("rs2_busy", bus.rs2_busy, b2);
    endtask

    task automatic model_update();
        bit acc [LANES];
        bit any;
        any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            acc[l] = bus.iss_valid[l] && can_issue(l);
            for (int i = 0; i < NREG; i++) any |= busy_m[l][i];
        end
        if (mode_m) begin
            if (bus.we[0] && fld(bus.wr_addr, 0) != 0) regs_m[fld(bus.wr_addr, 0)] = bus.wr_data;
        end else begin
            for (int l = 0; l < LANES; l++)
                if (bus.we[l] && fld(bus.wr_addr, l) != 0)
                    regs_m[fld(bus.wr_addr, l)][l*LANE_W +: LANE_W] =
                        bus.wr_data[l*LANE_W +: LANE_W];
        end
        for (int l = 0; l < LANES; l++) begin
            if (lane_on(l) && bus.we[l]) busy_m[l][fld(bus.wr_addr, l)] = 1'b0;
            if (acc[l] && fld(bus.iss_rd, l) != 0) busy_m[l][fld(bus.iss_rd, l)] = 1'b1;
        end
        case (phase_m)
            0: if (bus.mode_req != mode_m) phase_m = 1;
            1: if (!any) phase_m = 2;
            default: begin
                mode_m  = bus.mode_req;
                phase_m = 0;
                for (int l = 0; l < LANES; l++)
                    for (int i = 0; i < NREG; i++) busy_m[l][i] = 1'b0;
            end
        endcase
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.iss_valid = '0;
        bus.iss_rd    = '0;
        bus.we        = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.mode_req = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        #1 check_eq("rst_mode_busy", bus.mode_busy, 1'b0);
        step();
        rst = 1'b0;

        // Split mode: both lanes write their slice of r5 at once.
        idle(); bus.we = 2'b11; bus.wr_addr = {5'd5, 5'd5};
        bus.wr_data = {32'h5555_5555, 32'hAAAA_AAAA};
        step();
        idle(); bus.rs1 = {5'd0, 5'd5};
        #1 check_eq("split_r5", bus.rd1[63:0], 64'h5555_5555_AAAA_AAAA);
        step();

        // Scoreboard: WAW block, writeback clear, set-wins collision.
        idle(); bus.iss_valid = 2'b01; bus.iss_rd = {5'd0, 5'd7};
        step();
        idle(); bus.iss_valid = 2'b01; bus.iss_rd = {5'd0, 5'd7}; bus.rs1 = {5'd0, 5'd7};
        #1 check_eq("waw_ready", bus.iss_ready[0], 1'b0);
        check_eq("waw_busy", bus.rs1_busy[0], 1'b1);
        step();
        idle(); bus.we = 2'b01; bus.wr_addr = {5'd0, 5'd7}; bus.rs1 = {5'd0, 5'd7};
        step();
        idle(); bus.rs1 = {5'd0, 5'd7};
        #1 check_eq("wb_clear", bus.rs1_busy[0], 1'b0);
        step();
        idle(); bus.iss_valid = 2'b01; bus.iss_rd = {5'd0, 5'd7};
        bus.we = 2'b01; bus.wr_addr = {5'd0, 5'd7};
        step();
        idle(); bus.rs1 = {5'd0, 5'd7};
        #1 check_eq("set_wins", bus.rs1_busy[0], 1'b1);
        step();
        idle(); bus.we = 2'b01; bus.wr_addr = {5'd0, 5'd7};
        step();

        // Mode switch with r9 pending.
        idle(); bus.iss_valid = 2'b01; bus.iss_rd = {5'd0, 5'd9};
        step();
        idle(); bus.mode_req = 1'b1;
        step();
        idle(); bus.iss_valid = 2'b01; bus.iss_rd = {5'd0, 5'd1};
        #1 check_eq("drain_busy", bus.mode_busy, 1'b1);
        check_eq("drain_ready", bus.iss_ready, 2'b00);
        check_eq("drain_mode", bus.mode, 1'b0);
        step();
        idle(); step();
        idle(); bus.we = 2'b01; bus.wr_addr = {5'd0, 5'd9};
        step();
        idle(); step();
        idle(); step();
        idle(); bus.rs1 = {5'd0, 5'd5};
        #1 check_eq("switched", bus.mode, 1'b1);
        check_eq("kept_r5", bus.rd1[63:0], 64'h5555_5555_AAAA_AAAA);
        step();

        // Unified: lane 0 writes the full word, lane 1 ignored, r0 stays zero.
        idle(); bus.we = 2'b11; bus.wr_addr = {5'd3, 5'd3};
        bus.wr_data = 64'h0123_4567_89AB_CDEF;
        step();
        idle(); bus.rs1 = {5'd0, 5'd3};
        #1 check_eq("uni_r3", bus.rd1[63:0], 64'h0123_4567_89AB_CDEF);
        step();
        idle(); bus.we = 2'b01; bus.wr_addr = '0; bus.wr_data = '1;
        step();
        idle(); bus.rs1 = '0;
        #1 check_eq("r0_zero", bus.rd1[63:0], 64'h0);
        step();

        // Same-cycle read of a write.
        idle(); bus.we = 2'b01; bus.wr_addr = {5'd0, 5'd4};
        bus.wr_data = 64'h1234; bus.rs1 = {5'd0, 5'd4};
`ifdef REGFILE_BYPASS_EN
        #1 check_eq("fwd_same", bus.rd1[63:0], 64'h1234);
`else
        #1 check_eq("fwd_same", bus.rd1[63:0], 64'h0);
`endif
        step();
        idle(); bus.rs1 = {5'd0, 5'd4};
        #1 check_eq("fwd_next", bus.rd1[63:0], 64'h1234);
        step();

        // Reset in the middle of a drain.
        idle(); bus.iss_valid = 2'b01; bus.iss_rd = {5'd0, 5'd9};
        step();
        idle(); bus.mode_req = 1'b0;
        step();
        idle(); step();
        idle(); bus.rs1 = {5'd0, 5'd9}; bus.rs2 = {5'd0, 5'd3};
        #1 check_eq("pre_rst_busy", bus.mode_busy, 1'b1);
        rst = 1'b1;
        #1 check_eq("rst_mode", bus.mode, 1'b0);
        check_eq("rst_mbusy", bus.mode_busy, 1'b0);
        check_eq("rst_sb", bus.rs1_busy[0], 1'b0);
        check_eq("rst_regs", bus.rd2[63:0], 64'h0);
        model_reset();
        step();
        rst = 1'b0;

        // Randomized traffic with occasional mode flips.
        for (int n = 0; n < 800; n++) begin
            bus.iss_valid = 2'($urandom);
            bus.iss_rd    = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.we        = 2'($urandom);
            bus.wr_addr   = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.wr_data   = {$urandom, $urandom};
            bus.rs1       = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.rs2       = {5'($urandom_range(7)), 5'($urandom_range(7))};
            if ($urandom_range(30) == 0) bus.mode_req = ~bus.mode_req;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
